shift_unit_seq: RTL

Parametrised multi-cycle shift unit: the successor to the fixed combinational left-shift-by-two used for branch/jump target formation. It performs SLL, SRL, SRA and optional rotate-right by a run-time shift amount, spending STEP bit-positions per clock. It sits beside the ALU in the execute path and is driven by a start/done handshake from the control FSM.

---
 rtl/shift_unit_seq.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/shift_unit_seq.sv
// -----------------------------------------------------------------------------
// shift_unit_seq
//   Multi-cycle shift unit for the execute path. It performs SLL, SRL and SRA
//   (plus ROTR when enabled) by a run-time amount, moving at most STEP
//   bit-positions per clock. The control FSM drives it with a start/done
//   handshake.
//
//   Optional feature macro: SHIFT_ROTATE_EN
//     defined   -> op=11 rotates right by shamt.
//     undefined -> op=11 passes data_in through with shamt=0 latency, and no
//                  rotate datapath is built.
//
//   Parameters
//     WIDTH    data width (power of two, >= 4)
//     STEP     maximum bit-positions shifted per clock (1..WIDTH)
//     SHAMT_W  shift-amount width, derived from WIDTH (do not override)
//
//   Ports
//     clk      rising-edge clock
//     rst      synchronous active-high reset
//     start    request, sampled only while busy=0
//     op       00 SLL, 01 SRL, 10 SRA, 11 ROTR / no-op
//     data_in  operand, latched on an accepted start
//     shamt    shift amount, latched on an accepted start
//     busy     high while a shift is in progress
//     done     one-cycle pulse, result valid
//     result   shifted value, held until the next accepted start or rst
//
//   state   | meaning
//   --------+-----------------------------------------------------------------
//   S_IDLE  | waiting for start; busy=0, done=0
//   S_SHIFT | shifting up to STEP positions per clock; busy=1
//   S_DONE  | one-cycle done pulse; a start here is accepted like in S_IDLE
// -----------------------------------------------------------------------------
module shift_unit_seq #(
  parameter int WIDTH   = 32,
  parameter int STEP    = 1,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_ROTR = 2'b11;

  // STEP may equal WIDTH, which does not fit in SHAMT_W bits, so the
  // per-clock step limit is compared one bit wider than the counter.
  localparam logic [SHAMT_W:0] STEP_W = (SHAMT_W+1)'(STEP);

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [SHAMT_W-1:0] step_k;
  logic [WIDTH-1:0]   shifted;

  // Positions to move this clock: min(STEP, remaining). When remaining is
  // not below STEP, STEP is at most WIDTH-1 and so fits the counter width.
  always_comb begin
    step_k = '0;
    if ({1'b0, rem_q} < STEP_W) begin
      step_k = rem_q;
    end else begin
      step_k = STEP_W[SHAMT_W-1:0];
    end
  end

  // SRA keeps the MSB on every step, so the operand's sign bit is what
  // fills in on each partial shift.
  always_comb begin
    shifted = result_q;
    case (op_q)
      OP_SLL:  shifted = result_q << step_k;
      OP_SRL:  shifted = result_q >> step_k;
      OP_SRA:  shifted = WIDTH'($signed(result_q) >>> step_k);
`ifdef SHIFT_ROTATE_EN
      // A left shift by WIDTH yields zero, so step_k=0 is a clean no-op.
      OP_ROTR: shifted = (result_q >> step_k) |
                         (result_q << (WIDTH - int'(step_k)));
`else
      OP_ROTR: shifted = result_q;
`endif
      default: shifted = result_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rem_d    = rem_q;
    result_d = result_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_SHIFT;
          op_d     = op;
          result_d = data_in;
          busy_d   = 1'b1;
`ifdef SHIFT_ROTATE_EN
          rem_d    = shamt;
`else
          // Without rotate support op=11 is a pass-through with the
          // latency of a zero-length shift.
          rem_d    = (op == OP_ROTR) ? '0 : shamt;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SHIFT: begin
        result_d = shifted;
        rem_d    = rem_q - step_k;
        if (rem_d == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_SLL;
      rem_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
